// File: rtl/p405s_icu_fill_ctl.sv
// I-cache line-fill controller: packs eight 32-bit wrap-order beats into two 128-bit halves
// and writes them into the ICU array, sharing its single port with fetch reads.
// Optional critical-beat forwarding is built when P405S_ICU_FILL_BYPASS_EN is defined.
module p405s_icu_fill_ctl (
    input  logic         cclk,
    input  logic         reset,
    input  logic         fill_start,
    input  logic [0:7]   fill_line,
    input  logic [0:2]   fill_word,
    input  logic         fill_valid,
    input  logic [0:31]  fill_data,
    input  logic         fill_err,
    output logic         fill_ready,
    output logic         fill_done,
    output logic         fill_abort,
    input  logic         fetch_req,
    input  logic [0:8]   fetch_addr,
    output logic         fetch_gnt,
    output logic         sram_cen,
    output logic         sram_readWrite,
    output logic [0:15]  sram_byteWrite,
    output logic [0:8]   sram_addr,
    output logic [0:127] sram_dataIn,
    output logic         byp_valid,
    output logic [0:31]  byp_data,
    output logic [0:2]   byp_word
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} fillState_t;

    fillState_t  state;
    logic [0:7]  lineQ;
    logic [0:2]  curWord;
    logic [2:0]  beatCnt;
    logic [2:0]  halfCnt [0:1];
    logic [1:0]  pending;
    logic [0:31] fillBuf [0:1][0:3];

    logic       curHalf;
    logic       beatAcc;
    logic       writeIssue;
    logic       issueHalf;
    logic [1:0] issueMask;
    logic [1:0] pendAfter;

    assign curHalf    = curWord[0];
    assign fill_ready = (state == FILL) && !pending[curHalf];
    assign beatAcc    = fill_valid && fill_ready;

    // Lower half wins when both are pending.
    assign writeIssue = |pending;
    assign issueHalf  = !pending[0];
    assign issueMask  = writeIssue ? (issueHalf ? 2'b10 : 2'b01) : 2'b00;
    assign pendAfter  = pending & ~issueMask;
    assign fetch_gnt  = fetch_req && !writeIssue;

    always_ff @(posedge cclk) begin
        if (beatAcc)
            fillBuf[curHalf][curWord[1:2]] <= fill_data;
    end

    always_ff @(posedge cclk) begin
        if (reset) begin
            state          <= IDLE;
            lineQ          <= '0;
            curWord        <= '0;
            beatCnt        <= '0;
            halfCnt[0]     <= '0;
            halfCnt[1]     <= '0;
            pending        <= '0;
            fill_done      <= 1'b0;
            fill_abort     <= 1'b0;
            sram_cen       <= 1'b1;
            sram_readWrite <= 1'b1;
            sram_byteWrite <= '1;
            sram_addr      <= '0;
            sram_dataIn    <= '0;
        end else begin
            fill_done  <= 1'b0;
            fill_abort <= 1'b0;

            if (writeIssue) begin
                sram_cen       <= 1'b0;
                sram_readWrite <= 1'b0;
                sram_byteWrite <= '0;
                sram_addr      <= {lineQ, issueHalf};
                sram_dataIn    <= {fillBuf[issueHalf][0], fillBuf[issueHalf][1],
                                   fillBuf[issueHalf][2], fillBuf[issueHalf][3]};
            end else if (fetch_req) begin
                sram_cen       <= 1'b0;
                sram_readWrite <= 1'b1;
                sram_byteWrite <= '1;
                sram_addr      <= fetch_addr;
            end else begin
                sram_cen       <= 1'b1;
                sram_readWrite <= 1'b1;
                sram_byteWrite <= '1;
            end

            pending <= pendAfter;

            case (state)
                IDLE: begin
                    if (fill_start) begin
                        state      <= FILL;
                        lineQ      <= fill_line;
                        curWord    <= fill_word;
                        beatCnt    <= '0;
                        halfCnt[0] <= '0;
                        halfCnt[1] <= '0;
                    end
                end
                FILL: begin
                    if (beatAcc) begin
                        if (fill_err) begin
                            // Drop anything not yet on the port; a half already written stays.
                            pending    <= '0;
                            fill_abort <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            curWord          <= curWord + 3'd1;
                            beatCnt          <= beatCnt + 3'd1;
                            halfCnt[curHalf] <= halfCnt[curHalf] + 3'd1;
                            if (halfCnt[curHalf] == 3'd3)
                                pending <= pendAfter | (2'b01 << curHalf);
                            if (beatCnt == 3'd7)
                                state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pendAfter == 2'b00) begin
                        state     <= IDLE;
                        fill_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef P405S_ICU_FILL_BYPASS_EN
    logic bypTake;
    assign bypTake = beatAcc && (beatCnt == 3'd0) && !fill_err;

    always_ff @(posedge cclk) begin
        if (reset) begin
            byp_valid <= 1'b0;
            byp_data  <= '0;
            byp_word  <= '0;
        end else begin
            byp_valid <= bypTake;
            if (bypTake) begin
                byp_data <= fill_data;
                byp_word <= curWord;
            end
        end
    end
`else
    assign byp_valid = 1'b0;
    assign byp_data  = '0;
    assign byp_word  = '0;
`endif

endmodule

// File: tb/tb_p405s_icu_fill_ctl.sv
// Bench for p405s_icu_fill_ctl: directed scenarios plus random fills, scored against
// a cycle-numbered write/read schedule derived from the fill rules.
module tb_p405s_icu_fill_ctl;

    logic         cclk = 1'b0;
    logic         reset;
    logic         fill_start;
    logic [0:7]   fill_line;
    logic [0:2]   fill_word;
    logic         fill_valid;
    logic [0:31]  fill_data;
    logic         fill_err;
    logic         fill_ready;
    logic         fill_done;
    logic         fill_abort;
    logic         fetch_req;
    logic [0:8]   fetch_addr;
    logic         fetch_gnt;
    logic         sram_cen;
    logic         sram_readWrite;
    logic [0:15]  sram_byteWrite;
    logic [0:8]   sram_addr;
    logic [0:127] sram_dataIn;
    logic         byp_valid;
    logic [0:31]  byp_data;
    logic [0:2]   byp_word;

    p405s_icu_fill_ctl dut (
        .cclk(cclk), .reset(reset),
        .fill_start(fill_start), .fill_line(fill_line), .fill_word(fill_word),
        .fill_valid(fill_valid), .fill_data(fill_data), .fill_err(fill_err),
        .fill_ready(fill_ready), .fill_done(fill_done), .fill_abort(fill_abort),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .sram_cen(sram_cen), .sram_readWrite(sram_readWrite), .sram_byteWrite(sram_byteWrite),
        .sram_addr(sram_addr), .sram_dataIn(sram_dataIn),
        .byp_valid(byp_valid), .byp_data(byp_data), .byp_word(byp_word)
    );

    always #5 cclk = ~cclk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int           at;
        logic [8:0]   addr;
        logic [127:0] data;
    } wr_t;

    // Reference state: which fill is in flight and what the port must show at each edge.
    wr_t         wrQ[$];
    bit          mBusy, mFilling, mAcc, lastGnt;
    logic [7:0]  mLine;
    logic [2:0]  mWord;
    int          mBeats;
    int          mCnt [2];
    logic [31:0] mMem [8];
    int          rstEdge = -1, doneEdge = -1, abortEdge = -1, bypEdge = -1, readEdge = -1;
    logic [31:0] bypData;
    logic [2:0]  bypWord;
    logic [8:0]  readAddr;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Evaluated just before edge cyc+1 with this cycle's inputs stable.
    task automatic modelPre();
        int  ed;
        int  w;
        bit  h;
        bit  wrNow;
        wr_t wr;
        ed   = cyc + 1;
        mAcc = 0;
        if (reset) begin
            wrQ.delete();
            mBusy = 0; mFilling = 0; lastGnt = 0;
            rstEdge = ed; doneEdge = -1; abortEdge = -1; bypEdge = -1; readEdge = -1;
            return;
        end
        wrNow   = (wrQ.size() > 0) && (wrQ[0].at == ed);
        lastGnt = fetch_req && !wrNow;
        chk("fetch_gnt", fetch_gnt, lastGnt);
        if (lastGnt) begin readEdge = ed; readAddr = fetch_addr; end
        chk("fill_ready", fill_ready, mFilling);
        if (!mBusy && fill_start) begin
            mBusy = 1; mFilling = 1; mLine = fill_line; mWord = fill_word;
            mBeats = 0; mCnt[0] = 0; mCnt[1] = 0;
        end else if (mFilling && fill_valid) begin
            mAcc = 1;
            if (fill_err) begin
                mFilling = 0; mBusy = 0; abortEdge = ed;
                while (wrQ.size() > 0 && wrQ[wrQ.size()-1].at > ed) void'(wrQ.pop_back());
            end else begin
                w = (int'(mWord) + mBeats) % 8;
                h = 1'(w / 4);
                mMem[w] = fill_data;
                if (mBeats == 0) begin bypEdge = ed; bypData = fill_data; bypWord = mWord; end
                mCnt[h]++;
                if (mCnt[h] == 4) begin
                    wr.at   = ed + 1;
                    wr.addr = {mLine, h};
                    wr.data = {mMem[4*h], mMem[4*h+1], mMem[4*h+2], mMem[4*h+3]};
                    wrQ.push_back(wr);
                end
                mBeats++;
                if (mBeats == 8) begin mFilling = 0; doneEdge = ed + 1; end
            end
        end
        if (mBusy && !mFilling && ed == doneEdge) mBusy = 0;
    endtask

    // Evaluated just after edge cyc.
    task automatic modelPost();
        wr_t wr;
        if (rstEdge == cyc) begin
            chk("rst_cen", sram_cen, 1'b1);
            chk("rst_rw", sram_readWrite, 1'b1);
            chk("rst_bw", sram_byteWrite, 16'hFFFF);
            chk("rst_addr", sram_addr, 9'h0);
            chk("rst_data", sram_dataIn, 128'h0);
            chk("rst_ready", fill_ready, 1'b0);
            chk("rst_done", fill_done, 1'b0);
            chk("rst_abort", fill_abort, 1'b0);
            chk("rst_byp", {byp_valid, byp_data, byp_word}, 36'h0);
            return;
        end
        if (wrQ.size() > 0 && wrQ[0].at == cyc) begin
            wr = wrQ.pop_front();
            chk("wr_cen", sram_cen, 1'b0);
            chk("wr_rw", sram_readWrite, 1'b0);
            chk("wr_bw", sram_byteWrite, 16'h0000);
            chk("wr_addr", sram_addr, wr.addr);
            chk("wr_data", sram_dataIn, wr.data);
        end else if (readEdge == cyc) begin
            chk("rd_cen", sram_cen, 1'b0);
            chk("rd_rw", sram_readWrite, 1'b1);
            chk("rd_bw", sram_byteWrite, 16'hFFFF);
            chk("rd_addr", sram_addr, readAddr);
        end else begin
            chk("idle_cen", sram_cen, 1'b1);
            chk("idle_bw", sram_byteWrite, 16'hFFFF);
        end
        chk("fill_done", fill_done, doneEdge == cyc);
        chk("fill_abort", fill_abort, abortEdge == cyc);
`ifdef P405S_ICU_FILL_BYPASS_EN
        chk("byp_valid", byp_valid, bypEdge == cyc);
        if (bypEdge == cyc) begin
            chk("byp_data", byp_data, bypData);
            chk("byp_word", byp_word, bypWord);
        end
`else
        chk("byp_tied", {byp_valid, byp_data, byp_word}, 36'h0);
`endif
    endtask

    task automatic tick();
        @(negedge cclk);
        modelPre();
        @(posedge cclk);
        #1;
        cyc++;
        modelPost();
    endtask

    task automatic driveFetch(input int pct);
        if (!fetch_req || lastGnt) begin
            fetch_req  = ($urandom % 100) < pct;
            fetch_addr = 9'($urandom);
        end
    endtask

    task automatic doReset(input int n);
        reset = 1; fill_start = 0; fill_valid = 0; fill_err = 0; fetch_req = 0;
        repeat (n) tick();
        reset = 0;
    endtask

    task automatic waitIdle(input int pct);
        for (int i = 0; i < 40 && mBusy; i++) begin
            fill_start = 0; fill_err = 0;
            fill_valid = 1'($urandom); fill_data = $urandom;
            driveFetch(pct);
            tick();
        end
        chk("drain_bound", mBusy, 1'b0);
    endtask

    task automatic runFill(input logic [7:0] line, input logic [2:0] word, input int errIdx,
                           input int stopAfter, input int validPct, input int fetchPct,
                           input bit seqData);
        int nAcc;
        int limit;
        bit aborted;
        waitIdle(fetchPct);
        fill_start = 1; fill_line = line; fill_word = word; fill_valid = 0; fill_err = 0;
        driveFetch(fetchPct);
        tick();
        nAcc = 0; aborted = 0;
        limit = (stopAfter < 0) ? 8 : stopAfter;
        for (int n = 0; n < 300 && nAcc < limit && !aborted; n++) begin
            fill_valid = ($urandom % 100) < validPct;
            fill_data  = seqData ? 32'(nAcc) : $urandom;
            fill_err   = fill_valid && (nAcc == errIdx);
            fill_start = ($urandom % 6) == 0;
            fill_line  = 8'($urandom);
            fill_word  = 3'($urandom);
            driveFetch(fetchPct);
            tick();
            if (mAcc) begin
                nAcc++;
                if (fill_err) aborted = 1;
            end
        end
        chk("beat_bound", (nAcc >= limit) || aborted, 1'b1);
        fill_start = 0; fill_valid = 0; fill_err = 0;
    endtask

    initial begin
        reset = 1; fill_start = 0; fill_line = '0; fill_word = '0; fill_valid = 0;
        fill_data = '0; fill_err = 0; fetch_req = 0; fetch_addr = '0;
        mBusy = 0; mFilling = 0; lastGnt = 0;
        doReset(2);

        runFill(8'h2A, 3'd0, -1, -1, 100, 0, 1'b1);            // aligned, writes 0x054 then 0x055
        runFill(8'($urandom), 3'd5, -1, -1, 100, 0, 1'b0);     // wrap from word 5
        runFill(8'($urandom), 3'd0, -1, -1, 100, 100, 1'b0);   // fetch saturating the port
        runFill(8'h11, 3'd0, 5, -1, 100, 30, 1'b0);            // error on the sixth beat
        runFill(8'($urandom), 3'd2, -1, 3, 100, 0, 1'b0);      // cut short by reset
        doReset(1);
        runFill(8'($urandom), 3'd7, -1, -1, 100, 20, 1'b0);

        for (int k = 0; k < 25; k++)
            runFill(8'($urandom), 3'($urandom),
                    (($urandom % 4) == 0) ? int'($urandom_range(7, 0)) : -1,
                    -1, int'($urandom_range(100, 40)), int'($urandom_range(70, 0)), 1'b0);

        waitIdle(0);
        fetch_req = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
